// File: rtl/tinytpu_pkg.sv
// Shared types and constants for the tinytpu serial operand loader.
//   state_e  : loader FSM states (idle, loading, full/awaiting core handshake)
//   ELEMS    : elements per operand matrix at the default size
//   BIT_CW   : bit-counter width at the default element width
//   ELEM_CW  : element-counter width at the default size
//   cw()     : counter width for a modulus, never narrower than one bit
package tinytpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull
  } state_e;

  localparam int unsigned DefaultDw = 8;
  localparam int unsigned DefaultN  = 3;

  localparam int unsigned ELEMS   = DefaultN * DefaultN;
  localparam int unsigned BIT_CW  = $clog2(DefaultDw);
  localparam int unsigned ELEM_CW = $clog2(ELEMS);

  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tpu_bit_deser.sv
// One operand stream of the serial loader: MSB-first shift register plus an
// element-indexed write into a packed row-major N x N matrix.
//   clk, rst_n  : clock, asynchronous active-low reset (clears matrix too)
//   clr_i       : synchronous clear of the partial shift register only
//   shift_en_i  : accept bit_i this cycle
//   write_en_i  : this bit completes an element; store it at elem_idx_i
//   elem_idx_i  : row-major element index
//   bit_i       : serial data bit
//   mat_o       : packed matrix, element k at [k*D_W +: D_W]
module tpu_bit_deser
  import tinytpu_pkg::*;
#(
  parameter int unsigned D_W = DefaultDw,
  parameter int unsigned N   = DefaultN,
  localparam int unsigned Elems  = N * N,
  localparam int unsigned ElemCw = cw(Elems)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   shift_en_i,
  input  logic                   write_en_i,
  input  logic [ElemCw-1:0]      elem_idx_i,
  input  logic                   bit_i,
  output logic [Elems*D_W-1:0]   mat_o
);

  logic [D_W-1:0]       shift_q, shift_d;
  logic [D_W-1:0]       elem;
  logic [Elems*D_W-1:0] mat_q, mat_d;

  // Element as it stands after this cycle's bit lands in the LSB.
  assign elem = {shift_q[D_W-2:0], bit_i};

  always_comb begin
    shift_d = shift_q;
    mat_d   = mat_q;
    if (clr_i) begin
      shift_d = '0;
    end else if (shift_en_i) begin
      shift_d = elem;
      if (write_en_i) begin
        for (int unsigned i = 0; i < Elems; i++) begin
          if (elem_idx_i == ElemCw'(i)) mat_d[i*D_W +: D_W] = elem;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      mat_q   <= '0;
    end else begin
      shift_q <= shift_d;
      mat_q   <= mat_d;
    end
  end

  assign mat_o = mat_q;

endmodule

// File: rtl/tinytpu_serial_loader.sv
// Bit-serial operand loader feeding the tinytpu systolic core. Deserializes the
// X and Y pin streams in lockstep into two N x N matrices and presents them
// with a valid/ready handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   data_in_x, data_in_y  : serial operand bits, MSB-first per element
//   load_en               : qualifies one bit per stream per cycle
//   init                  : synchronous clear/abort, beats any load_en bit
//   core_ready            : core accepts the operand pair
//   mat_x, mat_y          : packed row-major matrices
//   mat_valid             : both matrices complete and stable
//   busy                  : a load is in progress
//   overrun               : sticky, load_en seen while matrices were full
module tinytpu_serial_loader
  import tinytpu_pkg::*;
#(
  parameter int unsigned D_W = DefaultDw,
  parameter int unsigned N   = DefaultN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in_x,
  input  logic               data_in_y,
  input  logic               load_en,
  input  logic               init,
  input  logic               core_ready,
  output logic [N*N*D_W-1:0] mat_x,
  output logic [N*N*D_W-1:0] mat_y,
  output logic               mat_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned Elems  = N * N;
  localparam int unsigned BitCw  = cw(D_W);
  localparam int unsigned ElemCw = cw(Elems);

  state_e            state_q, state_d;
  logic [BitCw-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ElemCw-1:0] elem_cnt_q, elem_cnt_d;
  logic              mat_valid_q, mat_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              accept, last_bit, last_elem;

  assign accept    = load_en && !init && (state_q != StFull);
  assign last_bit  = (bit_cnt_q == BitCw'(D_W - 1));
  assign last_elem = (elem_cnt_q == ElemCw'(Elems - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    elem_cnt_d = elem_cnt_q;
    overrun_d  = overrun_q;
    if (init) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      elem_cnt_d = '0;
      overrun_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            state_d = StLoad;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (last_elem) begin
                elem_cnt_d = '0;
                state_d    = StFull;
              end else begin
                elem_cnt_d = elem_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StFull: begin
          // Bits arriving while full are dropped; only the flag records them.
          if (load_en) overrun_d = 1'b1;
          if (core_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    // Status outputs are registered copies of the next state.
    mat_valid_d = (state_d == StFull);
    busy_d      = (state_d == StLoad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      elem_cnt_q  <= '0;
      mat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      mat_valid_q <= mat_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  tpu_bit_deser #(
    .D_W (D_W),
    .N   (N)
  ) u_deser_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (init),
    .shift_en_i (accept),
    .write_en_i (accept && last_bit),
    .elem_idx_i (elem_cnt_q),
    .bit_i      (data_in_x),
    .mat_o      (mat_x)
  );

  tpu_bit_deser #(
    .D_W (D_W),
    .N   (N)
  ) u_deser_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (init),
    .shift_en_i (accept),
    .write_en_i (accept && last_bit),
    .elem_idx_i (elem_cnt_q),
    .bit_i      (data_in_y),
    .mat_o      (mat_y)
  );

  assign mat_valid = mat_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tinytpu_serial_loader.sv
// Bench for tinytpu_serial_loader: element-level reference model (arrays of
// expected elements, updated whenever a full element has been sent) with
// randomized operands, idle-cycle data noise and random pauses.
module tb_tinytpu_serial_loader;

  localparam int D_W   = 8;
  localparam int N     = 3;
  localparam int ELEMS = N * N;
  localparam int MW    = ELEMS * D_W;
  localparam int NBITS = ELEMS * D_W;

  logic          clk = 1'b0;
  logic          rst_n, data_in_x, data_in_y, load_en, init, core_ready;
  logic [MW-1:0] mat_x, mat_y;
  logic          mat_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  logic [D_W-1:0] src_x[ELEMS];
  logic [D_W-1:0] src_y[ELEMS];
  logic [D_W-1:0] exp_x[ELEMS];
  logic [D_W-1:0] exp_y[ELEMS];

  always #5 clk = ~clk;

  tinytpu_serial_loader #(
    .D_W (D_W),
    .N   (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in_x  (data_in_x),
    .data_in_y  (data_in_y),
    .load_en    (load_en),
    .init       (init),
    .core_ready (core_ready),
    .mat_x      (mat_x),
    .mat_y      (mat_y),
    .mat_valid  (mat_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [MW-1:0] pack(input logic [D_W-1:0] e[ELEMS]);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N+c)*D_W +: D_W] = e[r*N+c];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      load_en   = 1'b0;
      data_in_x = 1'($urandom);
      data_in_y = 1'($urandom);
      tick();
    end
  endtask

  task automatic rand_src();
    for (int i = 0; i < ELEMS; i++) begin
      src_x[i] = D_W'($urandom);
      src_y[i] = D_W'($urandom);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < ELEMS; i++) begin
      exp_x[i] = '0;
      exp_y[i] = '0;
    end
  endtask

  // Send serial bits k0..k1-1 of the current sources; stream bit k belongs to
  // element k/D_W, MSB first. A completed element is what the matrix must hold.
  task automatic drive_bits(input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      load_en   = 1'b1;
      data_in_x = src_x[k/D_W][D_W-1-(k%D_W)];
      data_in_y = src_y[k/D_W][D_W-1-(k%D_W)];
      tick();
      if (k % D_W == D_W - 1) begin
        exp_x[k/D_W] = src_x[k/D_W];
        exp_y[k/D_W] = src_y[k/D_W];
      end
    end
    load_en   = 1'b0;
    data_in_x = 1'($urandom);
    data_in_y = 1'($urandom);
  endtask

  task automatic handshake();
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; init = 1'b0; core_ready = 1'b0;
    data_in_x = 1'b0; data_in_y = 1'b0;
    zero_model();
    tick(); tick();
    checks++; if (mat_x !== '0) begin failures++; $display("FAIL reset_mat_x got=%h exp=0", mat_x); end
    checks++; if (mat_y !== '0) begin failures++; $display("FAIL reset_mat_y got=%h exp=0", mat_y); end
    checks++; if ({mat_valid, busy, overrun} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {mat_valid, busy, overrun});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    for (int i = 0; i < ELEMS; i++) begin
      src_x[i] = D_W'(i + 1);
      src_y[i] = D_W'(ELEMS - i);
    end
    drive_bits(0, 1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    drive_bits(1, NBITS - 1);
    checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", mat_valid); end
    drive_bits(NBITS - 1, NBITS);
    checks++; if ({mat_valid, busy} !== 2'b10) begin
      failures++; $display("FAIL basic_done got=%b exp=10", {mat_valid, busy});
    end
    checks++; if (mat_x[7:0] !== 8'd1 || mat_x[71:64] !== 8'd9 || mat_y[7:0] !== 8'd9) begin
      failures++; $display("FAIL basic_corners got=%h/%h/%h exp=01/09/09", mat_x[7:0], mat_x[71:64], mat_y[7:0]);
    end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL basic_mats got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
    handshake();
    checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", mat_valid); end
  endtask

  task automatic test_pause();
    for (int i = 0; i < ELEMS; i++) begin
      src_x[i] = D_W'(i + 1);
      src_y[i] = D_W'(ELEMS - i);
    end
    drive_bits(0, 20);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++; if ({mat_valid, busy} !== 2'b01) begin
        failures++; $display("FAIL pause_hold got=%b exp=01 cycle=%0d", {mat_valid, busy}, i);
      end
    end
    drive_bits(20, NBITS - 1);
    checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL pause_early_valid got=%b exp=0", mat_valid); end
    drive_bits(NBITS - 1, NBITS);
    checks++; if (mat_valid !== 1'b1) begin failures++; $display("FAIL pause_valid got=%b exp=1", mat_valid); end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL pause_mats got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
    handshake();
  endtask

  task automatic test_hold_handshake();
    int bad;
    rand_src();
    drive_bits(0, NBITS);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      core_ready = 1'b0;
      idle(1);
      if (mat_valid !== 1'b1 || mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
    handshake();
    checks++; if ({mat_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL hold_release got=%b exp=00", {mat_valid, busy});
    end
    core_ready = 1'b1;
    idle(2);
    core_ready = 1'b0;
    checks++; if ({mat_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL ready_in_idle got=%b exp=00", {mat_valid, busy});
    end
  endtask

  task automatic test_overrun();
    rand_src();
    drive_bits(0, NBITS);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    for (int i = 0; i < 3; i++) begin
      load_en = 1'b1; data_in_x = 1'($urandom); data_in_y = 1'($urandom);
      tick();
      idle(1);
    end
    checks++; if ({overrun, mat_valid} !== 2'b11) begin
      failures++; $display("FAIL overrun_set got=%b exp=11", {overrun, mat_valid});
    end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL overrun_mats got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++; if ({overrun, mat_valid, busy} !== 3'b000) begin
      failures++; $display("FAIL overrun_init got=%b exp=000", {overrun, mat_valid, busy});
    end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL init_keeps_mats got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
  endtask

  task automatic test_init_abort();
    rand_src();
    drive_bits(0, 40);
    init = 1'b1; load_en = 1'b1; data_in_x = 1'($urandom); data_in_y = 1'($urandom);
    tick();
    init = 1'b0; load_en = 1'b0;
    checks++; if ({mat_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL abort_flags got=%b exp=00", {mat_valid, busy});
    end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL abort_partial got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
    for (int i = 0; i < ELEMS; i++) begin
      src_x[i] = 8'hA5;
      src_y[i] = 8'hA5;
    end
    drive_bits(0, NBITS - 1);
    checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL a5_early_valid got=%b exp=0", mat_valid); end
    drive_bits(NBITS - 1, NBITS);
    checks++; if (mat_valid !== 1'b1 || mat_x !== {ELEMS{8'hA5}} || mat_y !== {ELEMS{8'hA5}}) begin
      failures++; $display("FAIL a5_load got=%b %h %h exp=1 all a5", mat_valid, mat_x, mat_y);
    end
    handshake();
  endtask

  task automatic test_init_last_bit();
    rand_src();
    drive_bits(0, NBITS - 1);
    init = 1'b1; load_en = 1'b1;
    data_in_x = src_x[ELEMS-1][0]; data_in_y = src_y[ELEMS-1][0];
    tick();
    init = 1'b0; load_en = 1'b0;
    idle(1);
    checks++; if ({mat_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL init_last_flags got=%b exp=00", {mat_valid, busy});
    end
    checks++; if (mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL init_last_mats got=%h %h exp=%h %h", mat_x, mat_y, pack(exp_x), pack(exp_y));
    end
  endtask

  task automatic test_reset_midload();
    rand_src();
    drive_bits(0, 30);
    #3;
    rst_n = 1'b0;
    #1;
    zero_model();
    checks++; if (mat_x !== '0 || mat_y !== '0 || {mat_valid, busy, overrun} !== 3'b000) begin
      failures++; $display("FAIL async_reset got=%h %h %b exp=0 0 000", mat_x, mat_y, {mat_valid, busy, overrun});
    end
    tick();
    rst_n = 1'b1;
    tick();
    rand_src();
    drive_bits(0, NBITS - 1);
    checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL post_reset_early got=%b exp=0", mat_valid); end
    drive_bits(NBITS - 1, NBITS);
    checks++; if (mat_valid !== 1'b1 || mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
      failures++; $display("FAIL post_reset_load got=%b %h %h exp=1 %h %h", mat_valid, mat_x, mat_y,
                           pack(exp_x), pack(exp_y));
    end
    handshake();
  endtask

  task automatic test_random_loads();
    int bad;
    for (int it = 0; it < 6; it++) begin
      rand_src();
      bad = 0;
      for (int k = 0; k < NBITS; k++) begin
        if (k == NBITS - 1 && mat_valid !== 1'b0) bad++;
        drive_bits(k, k + 1);
        if (k < NBITS - 1 && $urandom_range(0, 4) == 0) begin
          idle($urandom_range(1, 3));
          if ({mat_valid, busy} !== 2'b01) bad++;
        end
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rand_progress it=%0d got=%0d bad exp=0", it, bad); end
      checks++; if (mat_valid !== 1'b1 || mat_x !== pack(exp_x) || mat_y !== pack(exp_y)) begin
        failures++; $display("FAIL rand_load it=%0d got=%b %h %h exp=1 %h %h", it, mat_valid, mat_x, mat_y,
                             pack(exp_x), pack(exp_y));
      end
      idle($urandom_range(0, 4));
      handshake();
      checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL rand_release it=%0d got=%b exp=0", it, mat_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_pause();
    test_hold_handshake();
    test_overrun();
    test_init_abort();
    test_init_last_bit();
    test_reset_midload();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
